s2mm_stream_arbiter: RTL
========================

Name: s2mm_stream_arbiter

Overview:
- Shares the single S2MM data stream of the circular DMA between two capture sources.
- Packet-granular round-robin: a grant holds from the first beat to tlast.
- Output is fully registered (2-entry skid buffer) and feeds m_axis directly into the DMA's S_AXIS_S2MM port.
- Enforces a maximum packet length by truncating oversized packets and discarding their remainder.
- Keeps per-source packet and truncation counters for software statistics.

Parameters:
- C_AXIS_WIDTH, 64, data width of all streams.
- C_MAX_BEATS, 256, maximum beats per forwarded packet (>=2).
- C_CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  0: no new grant issued; a packet in progress completes
- s0_axis_tdata  in  C_AXIS_WIDTH  source 0 data
- s0_axis_tlast  in  1  source 0 end of packet
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata/tlast/tvalid/tready  same as s0, source 1
- m_axis_tdata  out  C_AXIS_WIDTH  to DMA
- m_axis_tlast  out  1
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- pkt_count0  out  C_CNT_WIDTH  packets forwarded from source 0, wraps
- pkt_count1  out  C_CNT_WIDTH  packets forwarded from source 1, wraps
- trunc_count  out  C_CNT_WIDTH  packets truncated, both sources, wraps
- busy  out  1  state != IDLE or skid buffer not empty

Behaviour:
- Reset (async assert, sync release): state IDLE, last_grant=1 (so source 0 wins first), skid buffer empty.
  - Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s*_tready=0, all counters 0, busy=0.
- States: IDLE, PASS0, PASS1, DROP0, DROP1.
- IDLE -> grant, decided in 1 cycle; no beat is accepted in that cycle.
  - Arbitration needs enable=1. Candidates are the sources with tvalid=1.
  - Both valid: grant the source != last_grant.
  - Grant 0 -> PASS0, grant 1 -> PASS1; last_grant updated on grant.
- PASSn:
  - s{n}_tready = skid buffer has a free slot; the other source's tready=0.
  - Beat counter starts at 1 on the first beat.
  - Accepted beat with tlast: push with tlast=1, pkt_count{n}++, -> IDLE.
  - Accepted beat number C_MAX_BEATS without tlast: push with tlast=1 (forced), pkt_count{n}++, trunc_count++, -> DROPn.
- DROPn:
  - s{n}_tready=1 unconditionally; beats are discarded, nothing pushed.
  - Beat with tlast -> IDLE.
- Skid buffer: 2 entries.
  - m_axis_* driven from registers only, no combinational path from s*_tvalid or m_axis_tready to outputs except via registers.
  - Full throughput of 1 beat/cycle while m_axis_tready=1.
  - Latency from accepted beat to m_axis_tvalid: 1 cycle.
- m_axis handshake:
  - tdata/tlast held stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a transfer.
- Simultaneous push and pop on a full buffer is legal: occupancy unchanged.
- enable deasserted mid-packet: packet completes, including DROP; next grant waits for enable=1.
- enable deasserted in IDLE: no grant; outputs drain normally.
- Counter wrap: all-ones + 1 = 0, no saturation.
- Reset mid-packet: buffer contents lost; the downstream DMA is reset by its own dm_rst_n.
- C_MAX_BEATS beat counter width: clog2(C_MAX_BEATS+1).

Optional Feature:
- Macro: S2MM_ARB_PRIORITY_EN
- Defined: fixed priority. Source 0 always wins when both are valid in IDLE; last_grant is ignored.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Round-robin: s0 and s1 each present three 4-beat packets continuously, m_axis_tready=1.
  - Output order s0,s1,s0,s1,s0,s1; 24 beats; tlast on beats 4,8,...,24.
  - pkt_count0=3, pkt_count1=3.
- Truncation: C_MAX_BEATS=8, s0 sends a 12-beat packet.
  - Output 8 beats, tlast on beat 8.
  - Beats 9-12 consumed with no output; trunc_count=1; next s1 packet forwarded intact.
- Backpressure: m_axis_tready toggles 1/0 every cycle during an 8-beat s1 packet.
  - All 8 beats out in order, no loss or duplication.
  - tdata stable while tvalid=1 and tready=0.
- Enable gating: enable=0 with s0 valid -> no beat accepted over 20 cycles.
  - enable=1 -> first output beat 2 cycles later.
  - Deassert enable on beat 2 of a 5-beat packet -> all 5 beats forwarded, then no further grant.
- Reset mid-packet: assert rst on beat 3 of 6.
  - m_axis_tvalid=0 and all counters=0 immediately, before the next clk edge.
  - After release, source 0 granted first.
- Priority build (S2MM_ARB_PRIORITY_EN): both sources continuously valid, 2-beat packets.
  - Only s0 packets forwarded over 10 packets; pkt_count1=0.

Source files
------------

// File: rtl/s2mm_stream_arbiter.sv
// s2mm_stream_arbiter: merges two AXI-Stream capture sources onto the single
// S2MM stream of the circular DMA. Grants are packet-granular round-robin,
// oversized packets are cut at C_MAX_BEATS (forced tlast) and their tail is
// discarded. The output is driven from a 2-entry skid buffer.
// Optional build macro: S2MM_ARB_PRIORITY_EN (fixed priority, source 0 wins).
module s2mm_stream_arbiter #(
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BEATS  = 256,
  parameter int C_CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [C_AXIS_WIDTH-1:0] s0_axis_tdata,
  input  logic                    s0_axis_tlast,
  input  logic                    s0_axis_tvalid,
  output logic                    s0_axis_tready,
  input  logic [C_AXIS_WIDTH-1:0] s1_axis_tdata,
  input  logic                    s1_axis_tlast,
  input  logic                    s1_axis_tvalid,
  output logic                    s1_axis_tready,
  output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [C_CNT_WIDTH-1:0]  pkt_count0,
  output logic [C_CNT_WIDTH-1:0]  pkt_count1,
  output logic [C_CNT_WIDTH-1:0]  trunc_count,
  output logic                    busy
);
  localparam int BW = $clog2(C_MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(C_MAX_BEATS);

  typedef enum logic [2:0] {IDLE, PASS0, PASS1, DROP0, DROP1} state_t;
  typedef struct packed {
    logic [C_AXIS_WIDTH-1:0] data;
    logic                    last;
  } beat_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [BW-1:0] beat_cnt, beat_cnt_nxt;
  logic          grant, src;

  // sources gathered into packed per-source vectors
  logic [1:0]                   s_valid, s_last, s_ready;
  logic [1:0][C_AXIS_WIDTH-1:0] s_data;

  // skid buffer: skid0 is the output register, skid1 the overflow slot
  beat_t      skid0, skid1, push_beat;
  logic [1:0] occ;
  logic       push, pop, free_slot;
  logic [1:0] cnt_inc;
  logic       trunc_inc;

  assign s_valid        = {s1_axis_tvalid, s0_axis_tvalid};
  assign s_last         = {s1_axis_tlast,  s0_axis_tlast};
  assign s_data         = {s1_axis_tdata,  s0_axis_tdata};
  assign s0_axis_tready = s_ready[0];
  assign s1_axis_tready = s_ready[1];

  assign free_slot     = (occ != 2'd2);
  assign pop           = (occ != 2'd0) && m_axis_tready;
  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = skid0.data;
  assign m_axis_tlast  = skid0.last;
  assign busy          = (state != IDLE) || (occ != 2'd0);

  // state, grant history and beat counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // arbitration, per-source ready, push decision and truncation
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    grant          = 1'b0;
    src            = (state == PASS1) || (state == DROP1);
    s_ready        = '0;
    push           = 1'b0;
    push_beat      = '0;
    cnt_inc        = '0;
    trunc_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && (|s_valid)) begin
`ifdef S2MM_ARB_PRIORITY_EN
          grant = ~s_valid[0];
`else
          grant = (&s_valid) ? ~last_grant : s_valid[1];
`endif
          last_grant_nxt = grant;
          beat_cnt_nxt   = '0;
          state_nxt      = grant ? PASS1 : PASS0;
        end
      end
      PASS0, PASS1: begin
        s_ready[src] = free_slot;
        if (s_valid[src] && free_slot) begin
          push           = 1'b1;
          push_beat.data = s_data[src];
          beat_cnt_nxt   = beat_cnt + 1'b1;
          if (s_last[src]) begin
            push_beat.last = 1'b1;
            cnt_inc[src]   = 1'b1;
            state_nxt      = IDLE;
          end else if (beat_cnt + 1'b1 == MAX_CNT) begin
            // oversized packet: close it here and swallow the rest
            push_beat.last = 1'b1;
            cnt_inc[src]   = 1'b1;
            trunc_inc      = 1'b1;
            state_nxt      = src ? DROP1 : DROP0;
          end
        end
      end
      DROP0, DROP1: begin
        s_ready[src] = 1'b1;
        if (s_valid[src] && s_last[src]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // skid buffer: head is the output register, second slot absorbs a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) skid0 <= push_beat;
          else             skid1 <= push_beat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) skid0 <= push_beat;
          else begin
            skid0 <= skid1;
            skid1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  // wrapping statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count0  <= '0;
      pkt_count1  <= '0;
      trunc_count <= '0;
    end else begin
      if (cnt_inc[0]) pkt_count0  <= pkt_count0 + 1'b1;
      if (cnt_inc[1]) pkt_count1  <= pkt_count1 + 1'b1;
      if (trunc_inc)  trunc_count <= trunc_count + 1'b1;
    end
  end
endmodule
